// File: rtl/mem_test_reader_pkg.sv
// Shared definitions for the memory test reader: FSM encoding, bus widths and
// the default expected-pattern base.
package mem_test_reader_pkg;

    localparam int          MEM_BYTE_W   = 8;
    localparam int          MEM_WORD_W   = 16;
    localparam logic [15:0] DEF_EXP_BASE = 16'h000A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_LO,
        ST_HI,
        ST_CHECK,
        ST_FIN
    } state_e;

endpackage

// File: rtl/mem_test_reader_if.sv
// Byte-wide memory read bus: word address, chip select and byte select out,
// one data byte back from the memory.
interface mem_test_reader_if #(
    parameter int ADDR_W = 8
);
    import mem_test_reader_pkg::*;

    logic [ADDR_W-1:0]     addr;
    logic                  cs;
    logic                  byte_sel;
    logic [MEM_BYTE_W-1:0] data_byte;

    modport master (output addr, output cs, output byte_sel, input data_byte);
    modport slave  (input addr, input cs, input byte_sel, output data_byte);
endinterface

// File: rtl/mem_test_reader.sv
// Sweeps every word of a byte-wide memory, rebuilds 16-bit words from low/high
// byte reads, compares them to EXP_BASE + addr and streams each word out.
module mem_test_reader
    import mem_test_reader_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter logic [15:0] EXP_BASE     = DEF_EXP_BASE,
    parameter int          READ_LATENCY = 1,
    parameter bit          STOP_ON_ERR  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    mem_test_reader_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [MEM_WORD_W-1:0] first_err_data,
    output logic                  word_valid,
    output logic [ADDR_W-1:0]     word_addr,
    output logic [MEM_WORD_W-1:0] word_data
);

    localparam int                WCNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(READ_LATENCY - 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ERR_MAX   = '1;
    localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W+1)'(1);

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    cs_q;
    logic                    bsel_q;
    logic [WCNT_W-1:0]       wait_q;
    logic [MEM_BYTE_W-1:0]   lo_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [ADDR_W:0]         err_q;
    logic [ADDR_W-1:0]       ferr_addr_q;
    logic [MEM_WORD_W-1:0]   ferr_data_q;
    logic                    wv_q;
    logic [ADDR_W-1:0]       waddr_q;
    logic [MEM_WORD_W-1:0]   wdata_q;

    logic [MEM_WORD_W-1:0]   exp_word;
    logic                    mismatch;
    logic [ADDR_W:0]         err_d;

    // word_data/addr hold the assembled word during CHECK, so compare against them
    always_comb begin
        exp_word = EXP_BASE + MEM_WORD_W'(addr_q);
        mismatch = (wdata_q != exp_word);
        err_d    = err_q;
        if (mismatch && (err_q != ERR_MAX))
            err_d = err_q + ERR_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            bsel_q      <= 1'b0;
            wait_q      <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            wv_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            wv_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_ISSUE;
                        addr_q      <= '0;
                        err_q       <= '0;
                        pass_q      <= 1'b0;
                        ferr_addr_q <= '0;
                        ferr_data_q <= '0;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b1;
                        bsel_q      <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wait_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_LAST) state_q <= ST_LO;
                    else                     wait_q  <= wait_q + WAIT_ONE;
                end
                ST_LO: begin
                    lo_q    <= bus.data_byte;
                    bsel_q  <= 1'b1;
                    state_q <= ST_HI;
                end
                ST_HI: begin
                    wdata_q <= {bus.data_byte, lo_q};
                    waddr_q <= addr_q;
                    wv_q    <= 1'b1;
                    bsel_q  <= 1'b0;
                    cs_q    <= 1'b0;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    err_q <= err_d;
                    if (mismatch && (err_q == '0)) begin
                        ferr_addr_q <= addr_q;
                        ferr_data_q <= wdata_q;
                    end
                    if ((addr_q == ADDR_LAST) || (STOP_ON_ERR && mismatch)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        addr_q  <= addr_q + ADDR_ONE;
                        cs_q    <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    pass_q  <= (err_q == '0);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.addr       = addr_q;
    assign bus.cs         = cs_q;
    assign bus.byte_sel   = bsel_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
    assign word_valid     = wv_q;
    assign word_addr      = waddr_q;
    assign word_data      = wdata_q;

endmodule

// File: tb/tb_mem_test_reader.sv
// Bench for mem_test_reader: three instances (default, stop-on-error, 2-cycle
// latency) against behavioural memories, table-driven sweeps plus corner cases.
module tb_mem_test_reader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [256];

    mem_test_reader_if #(.ADDR_W(8)) bus0 ();
    mem_test_reader_if #(.ADDR_W(8)) bus1 ();
    mem_test_reader_if #(.ADDR_W(8)) bus2 ();

    logic        st [3];
    logic        bz [3];
    logic        dn [3];
    logic        ps [3];
    logic [8:0]  ec [3];
    logic [7:0]  fa [3];
    logic [15:0] fd [3];
    logic        wv [3];
    logic [7:0]  wa [3];
    logic [15:0] wd [3];
    logic [7:0]  ad [3];
    logic        csv [3];
    logic        bsv [3];

    // Memory models: word fetched through READ_LATENCY cs-gated stages,
    // byte select applied on the output; junk when cs is low.
    logic [15:0] p0, p1, p2a, p2b;
    always @(posedge clk) begin
        p0  <= bus0.cs ? mem[bus0.addr] : 16'hDEAD;
        p1  <= bus1.cs ? mem[bus1.addr] : 16'hDEAD;
        p2a <= bus2.cs ? mem[bus2.addr] : 16'hDEAD;
        p2b <= p2a;
    end
    assign bus0.data_byte = bus0.cs ? (bus0.byte_sel ? p0[15:8]  : p0[7:0])  : 8'hA5;
    assign bus1.data_byte = bus1.cs ? (bus1.byte_sel ? p1[15:8]  : p1[7:0])  : 8'hA5;
    assign bus2.data_byte = bus2.cs ? (bus2.byte_sel ? p2b[15:8] : p2b[7:0]) : 8'hA5;

    assign ad[0] = bus0.addr; assign csv[0] = bus0.cs; assign bsv[0] = bus0.byte_sel;
    assign ad[1] = bus1.addr; assign csv[1] = bus1.cs; assign bsv[1] = bus1.byte_sel;
    assign ad[2] = bus2.addr; assign csv[2] = bus2.cs; assign bsv[2] = bus2.byte_sel;

    mem_test_reader #(.ADDR_W(8)) dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .bus(bus0),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(ec[0]),
        .first_err_addr(fa[0]), .first_err_data(fd[0]),
        .word_valid(wv[0]), .word_addr(wa[0]), .word_data(wd[0]));

    mem_test_reader #(.ADDR_W(8), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .bus(bus1),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(ec[1]),
        .first_err_addr(fa[1]), .first_err_data(fd[1]),
        .word_valid(wv[1]), .word_addr(wa[1]), .word_data(wd[1]));

    mem_test_reader #(.ADDR_W(8), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(st[2]), .bus(bus2),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(ec[2]),
        .first_err_addr(fa[2]), .first_err_data(fd[2]),
        .word_valid(wv[2]), .word_addr(wa[2]), .word_data(wd[2]));

    int total = 0;
    int bad   = 0;

    typedef struct { logic [7:0] a; logic [15:0] d; } sb_t;
    sb_t sbq [$];

    typedef struct {
        int          s;
        int          c1a;
        logic [15:0] c1d;
        int          c2a;
        logic [15:0] c2d;
        int          cyc;
        logic        ps;
        logic [8:0]  ec;
        logic [7:0]  fa;
        logic [15:0] fd;
        int          words;
    } vec_t;
    vec_t tbl [7];

    int          r_cyc, r_words, r_csl, r_bsh, r_ndone, r_busylow, r_bsnocs;
    logic [15:0] r_w05, r_wff;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset(input int s, input string tag);
        chk({tag, "_bus"},  32'({ad[s], csv[s], bsv[s]}), 32'd0);
        chk({tag, "_stat"}, 32'({bz[s], dn[s], ps[s], ec[s]}), 32'd0);
        chk({tag, "_ferr"}, 32'({fa[s], fd[s]}), 32'd0);
        chk({tag, "_word"}, 32'({wv[s], wa[s], wd[s]}), 32'd0);
    endtask

    task automatic mem_init(input int c1a, input logic [15:0] c1d,
                            input int c2a, input logic [15:0] c2d);
        for (int i = 0; i < 256; i++) mem[i] = 16'h000A + 16'(i);
        if (c1a >= 0) mem[c1a] = c1d;
        if (c2a >= 0) mem[c2a] = c2d;
    endtask

    // Pulses start, then watches the instance every cycle until done (+tail).
    // extra_at >= 0 drives a second start pulse at that cycle offset.
    task automatic run_sweep(input int s, input int extra_at, input int tail);
        sb_t e;
        int  cyc;
        sbq.delete();
        for (int i = 0; i < 256; i++) sbq.push_back('{a: 8'(i), d: mem[i]});
        r_cyc = -1; r_words = 0; r_csl = 0; r_bsh = 0; r_ndone = 0;
        r_busylow = 0; r_bsnocs = 0; r_w05 = 16'hxxxx; r_wff = 16'hxxxx;
        @(negedge clk); st[s] = 1'b1;
        @(negedge clk); st[s] = 1'b0;
        cyc = 1;
        forever begin
            if (wv[s]) begin
                r_words++;
                if (wa[s] == 8'h05) r_w05 = wd[s];
                if (wa[s] == 8'hFF) r_wff = wd[s];
                if (sbq.size() == 0) chk("sb_underflow", 32'(wa[s]), 32'hFFFF_FFFF);
                else begin
                    e = sbq.pop_front();
                    chk("sb_addr", 32'(wa[s]), 32'(e.a));
                    chk("sb_data", 32'(wd[s]), 32'(e.d));
                end
            end
            if (r_cyc < 0) begin
                if (!csv[s]) r_csl++;
                if (bsv[s])  r_bsh++;
                if (bsv[s] && !csv[s]) r_bsnocs++;
                if (!bz[s])  r_busylow++;
            end
            if (dn[s]) begin
                r_ndone++;
                if (r_cyc < 0) r_cyc = cyc;
            end
            if (r_cyc >= 0 && cyc >= r_cyc + tail) break;
            if (cyc > 3000 + tail) begin
                chk("sweep_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(negedge clk);
            cyc++;
            st[s] = (cyc == extra_at);
        end
        st[s] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        tbl[0] = '{s:0, c1a:-1,    c1d:16'h0,    c2a:-1,    c2d:16'h0,
                   cyc:1281, ps:1'b1, ec:9'd0, fa:8'h00, fd:16'h0000, words:256};
        tbl[1] = '{s:0, c1a:'h10,  c1d:16'hBEEF, c2a:-1,    c2d:16'h0,
                   cyc:1281, ps:1'b0, ec:9'd1, fa:8'h10, fd:16'hBEEF, words:256};
        tbl[2] = '{s:0, c1a:'h00,  c1d:16'h1111, c2a:'hFF,  c2d:16'h2222,
                   cyc:1281, ps:1'b0, ec:9'd2, fa:8'h00, fd:16'h1111, words:256};
        tbl[3] = '{s:1, c1a:'h20,  c1d:16'h1234, c2a:'h30,  c2d:16'h5678,
                   cyc:166,  ps:1'b0, ec:9'd1, fa:8'h20, fd:16'h1234, words:33};
        tbl[4] = '{s:1, c1a:-1,    c1d:16'h0,    c2a:-1,    c2d:16'h0,
                   cyc:1281, ps:1'b1, ec:9'd0, fa:8'h00, fd:16'h0000, words:256};
        tbl[5] = '{s:2, c1a:-1,    c1d:16'h0,    c2a:-1,    c2d:16'h0,
                   cyc:1537, ps:1'b1, ec:9'd0, fa:8'h00, fd:16'h0000, words:256};
        tbl[6] = '{s:2, c1a:'h80,  c1d:16'h0000, c2a:-1,    c2d:16'h0,
                   cyc:1537, ps:1'b0, ec:9'd1, fa:8'h80, fd:16'h0000, words:256};

        // reset state while reset is held low
        #3;
        for (int s = 0; s < 3; s++) check_reset(s, "por");
        do_reset();

        for (int t = 0; t < 7; t++) begin
            do_reset();
            mem_init(tbl[t].c1a, tbl[t].c1d, tbl[t].c2a, tbl[t].c2d);
            run_sweep(tbl[t].s, -1, 2);
            chk($sformatf("v%0d_cycles", t),   32'(r_cyc),     32'(tbl[t].cyc));
            chk($sformatf("v%0d_pass", t),     32'(ps[tbl[t].s]), 32'(tbl[t].ps));
            chk($sformatf("v%0d_errcnt", t),   32'(ec[tbl[t].s]), 32'(tbl[t].ec));
            chk($sformatf("v%0d_ferraddr", t), 32'(fa[tbl[t].s]), 32'(tbl[t].fa));
            chk($sformatf("v%0d_ferrdata", t), 32'(fd[tbl[t].s]), 32'(tbl[t].fd));
            chk($sformatf("v%0d_words", t),    32'(r_words),   32'(tbl[t].words));
            chk($sformatf("v%0d_cs_low", t),   32'(r_csl),     32'(tbl[t].words + 1));
            chk($sformatf("v%0d_bsel_hi", t),  32'(r_bsh),     32'(tbl[t].words));
            chk($sformatf("v%0d_bsel_nocs", t), 32'(r_bsnocs), 32'd0);
            chk($sformatf("v%0d_busy_in", t),  32'(r_busylow), 32'd0);
            chk($sformatf("v%0d_busy_after", t), 32'(bz[tbl[t].s]), 32'd0);
            chk($sformatf("v%0d_ndone", t),    32'(r_ndone),   32'd1);
            if (t == 0) begin
                chk("word_05", 32'(r_w05), 32'h000F);
                chk("word_ff", 32'(r_wff), 32'h0109);
            end
        end

        // start while busy is ignored: pulses 47 cycles apart
        do_reset();
        mem_init(-1, 16'h0, -1, 16'h0);
        repeat (2) @(negedge clk);
        run_sweep(0, 47, 1400);
        chk("dbl_start_cycles", 32'(r_cyc),   32'd1281);
        chk("dbl_start_ndone",  32'(r_ndone), 32'd1);
        chk("dbl_start_errcnt", 32'(ec[0]),   32'd0);
        chk("dbl_start_pass",   32'(ps[0]),   32'd1);

        // asynchronous reset in the middle of the sweep
        do_reset();
        @(negedge clk); st[0] = 1'b1;
        @(negedge clk); st[0] = 1'b0;
        for (int k = 0; k < 1000 && ad[0] != 8'h40; k++) @(negedge clk);
        chk("midrst_reach40", 32'(ad[0]), 32'h40);
        #2 reset = 1'b0;
        #1 check_reset(0, "midrst");
        @(negedge clk);
        reset = 1'b1;
        r_ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (dn[0]) r_ndone++;
        end
        chk("midrst_nodone", 32'(r_ndone), 32'd0);
        chk("midrst_idle",   32'(bz[0]),   32'd0);
        run_sweep(0, -1, 2);
        chk("midrst_cycles", 32'(r_cyc), 32'd1281);
        chk("midrst_pass",   32'(ps[0]), 32'd1);
        chk("midrst_errcnt", 32'(ec[0]), 32'd0);
        chk("midrst_words",  32'(r_words), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
